// File: rtl/serial_tx_queue.sv
// Byte FIFO feeding an 8N1 UART transmitter for the FPGA->AVR link.
// The AVR's rx-full flag (tx_block) is synchronised and only checked between frames.
module serial_tx_queue #(
  parameter int CLK_PER_BIT = 100,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       new_tx_data,
  output logic       tx_busy,
  input  logic       tx_block,
  output logic       tx,
  output logic       active,
  output logic       overflow
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CLK_PER_BIT);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;
  logic [7:0]    mem [FIFO_DEPTH];
  logic          blk_q1;
  logic          blk_s;
  logic [CW-1:0] bit_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
  logic          push;
  logic          pop;
  logic          bit_end;

  // Write handshake: new_tx_data is a one-cycle strobe, taken at the edge only
  // when tx_busy is low; a strobe while tx_busy is high is dropped and flagged
  // on overflow the following cycle. There is no other backpressure.
  assign tx_busy = (count == (PW+1)'(FIFO_DEPTH));
  assign push    = new_tx_data && !tx_busy;
  assign pop     = (state == IDLE) && (count != '0) && !blk_s;
  assign bit_end = (bit_cnt == CW'(CLK_PER_BIT - 1));

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= tx_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      blk_q1   <= 1'b0;
      blk_s    <= 1'b0;
    end else begin
      blk_q1   <= tx_block;
      blk_s    <= blk_q1;
      overflow <= new_tx_data && tx_busy;
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + (PW+1)'(push) - (PW+1)'(pop);
    end
  end

  // tx and active follow the state one cycle later, so both come straight from flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      bit_cnt <= '0;
      bit_idx <= '0;
      shift   <= '0;
      tx      <= 1'b1;
      active  <= 1'b0;
    end else begin
      tx     <= (state == START) ? 1'b0 : (state == DATA) ? shift[0] : 1'b1;
      active <= (state != IDLE);
      case (state)
        IDLE: begin
          bit_cnt <= '0;
          bit_idx <= '0;
          if (pop) begin
            shift <= mem[rd_ptr];
            state <= START;
          end
        end
        START: begin
          if (bit_end) begin
            bit_cnt <= '0;
            state   <= DATA;
          end else begin
            bit_cnt <= bit_cnt + CW'(1);
          end
        end
        DATA: begin
          if (bit_end) begin
            bit_cnt <= '0;
            shift   <= {1'b0, shift[7:1]};
            if (bit_idx == 3'd7) state <= STOP;
            else bit_idx <= bit_idx + 3'd1;
          end else begin
            bit_cnt <= bit_cnt + CW'(1);
          end
        end
        STOP: begin
          if (bit_end) begin
            bit_cnt <= '0;
            state   <= IDLE;
          end else begin
            bit_cnt <= bit_cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_tx_queue.sv
// Bench for serial_tx_queue: frame-level timing model plus UART receivers on a
// CLK_PER_BIT=4 instance and a CLK_PER_BIT=100 instance.
module tb_serial_tx_queue;
  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int CPB_F = 100;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] tx_data;
  logic       new_tx_data;
  logic       tx_block;
  logic       tx_busy, tx, active, overflow;
  logic [7:0] tx_data_f;
  logic       new_tx_data_f;
  logic       tx_block_f;
  logic       tx_busy_f, tx_f, active_f, overflow_f;

  serial_tx_queue #(.CLK_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .new_tx_data(new_tx_data),
    .tx_busy(tx_busy), .tx_block(tx_block), .tx(tx), .active(active),
    .overflow(overflow)
  );

  serial_tx_queue #(.CLK_PER_BIT(CPB_F), .FIFO_DEPTH(DEPTH)) dut_f (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data_f), .new_tx_data(new_tx_data_f),
    .tx_busy(tx_busy_f), .tx_block(tx_block_f), .tx(tx_f), .active(active_f),
    .overflow(overflow_f)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  // Reference model: FIFO contents as a queue, frame timing from start edge tp.
  logic [7:0] mq[$];
  logic [7:0] exp_q[$];
  logic [7:0] exp_qf[$];
  logic [7:0] rx_b[$];
  int         rx_t[$];
  int         tp = -100000;
  int         idle_from = 0;
  logic [7:0] fr_byte = 8'h00;
  bit         in_flight = 1'b0;
  bit         ovf_m = 1'b0;
  bit         h1 = 1'b0, h2 = 1'b0;

  task automatic model_step();
    bit busy_m, pop_m, push_m;
    cyc++;
    if (!rst_n) begin
      mq.delete();
      if (in_flight) void'(exp_q.pop_back());
      in_flight = 1'b0; tp = -100000; idle_from = 0; ovf_m = 1'b0; h1 = 1'b0; h2 = 1'b0;
    end else begin
      busy_m = (mq.size() == DEPTH);
      if (cyc >= tp + 10*CPB) in_flight = 1'b0;
      pop_m  = (cyc >= idle_from) && (mq.size() > 0) && !h2;
      push_m = new_tx_data && !busy_m;
      ovf_m  = new_tx_data && busy_m;
      if (pop_m) begin
        fr_byte = mq.pop_front();
        exp_q.push_back(fr_byte);
        tp = cyc;
        idle_from = cyc + 10*CPB + 1;
        in_flight = 1'b1;
      end
      if (push_m) mq.push_back(tx_data);
      h2 = h1;
      h1 = tx_block;
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial begin : cycle_chk
    logic etx, eact;
    int o;
    forever begin
      @(negedge clk);
      etx = 1'b1;
      eact = 1'b0;
      if (rst_n) begin
        o = cyc - tp - 1;
        if (o >= 0 && o < 10*CPB) begin
          eact = 1'b1;
          if (o / CPB == 0) etx = 1'b0;
          else if (o / CPB <= 8) etx = fr_byte[o/CPB - 1];
        end
        check("busy", tx_busy, mq.size() == DEPTH);
        check("overflow", overflow, ovf_m);
      end else begin
        check("busy_rst", tx_busy, 1'b0);
        check("overflow_rst", overflow, 1'b0);
      end
      check("tx", tx, etx);
      check("active", active, eact);
      check("overflow_f", overflow_f, 1'b0);
    end
  end

  function automatic logic line(input bit fast);
    return fast ? tx_f : tx;
  endfunction

  // Mid-bit sampling UART receiver; frames cut by reset are discarded.
  task automatic rx_mon(input bit fast);
    int cpb, t0;
    logic [7:0] b;
    logic st, sp;
    bit ok;
    cpb = fast ? CPB_F : CPB;
    forever begin
      @(negedge clk);
      if (rst_n && line(fast) == 1'b0) begin
        t0 = cyc; ok = 1'b1; st = 1'b1; sp = 1'b0; b = 8'h00;
        for (int off = 1; off <= 9*cpb + cpb/2; off++) begin
          @(negedge clk);
          if (!rst_n) ok = 1'b0;
          if (off % cpb == cpb/2) begin
            if (off / cpb == 0) st = line(fast);
            else if (off / cpb <= 8) b[off/cpb - 1] = line(fast);
            else sp = line(fast);
          end
        end
        if (ok) begin
          if (fast) begin
            check("rx_frame_f", {st, sp}, 2'b01);
            check("rx_expected_f", exp_qf.size() > 0, 1'b1);
            if (exp_qf.size() > 0) check("rx_byte_f", b, exp_qf.pop_front());
          end else begin
            check("rx_frame", {st, sp}, 2'b01);
            check("rx_expected", exp_q.size() > 0, 1'b1);
            if (exp_q.size() > 0) check("rx_byte", b, exp_q.pop_front());
            rx_b.push_back(b);
            rx_t.push_back(t0);
          end
        end
      end
    end
  endtask

  initial rx_mon(1'b0);
  initial rx_mon(1'b1);

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [7:0] d);
    tx_data = d;
    new_tx_data = 1'b1;
    @(posedge clk); #1;
    new_tx_data = 1'b0;
  endtask

  task automatic wait_quiet(input string tag, input int max);
    int w = 0;
    while (!(mq.size() == 0 && cyc >= tp + 10*CPB + 2) && w < max) begin
      @(posedge clk); #1; w++;
    end
    check(tag, w < max, 1'b1);
  endtask

  task automatic wait_tx_low(input string tag, output int k);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (tx !== 1'b0 && k < 200);
    check(tag, k < 200, 1'b1);
  endtask

  initial begin
    logic [39:0] got_tx, exp_tx, got_act;
    int k, w, s;
    rst_n = 1'b0; tx_data = 8'h00; new_tx_data = 1'b0; tx_block = 1'b0;
    tx_data_f = 8'h00; new_tx_data_f = 1'b0; tx_block_f = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    check("rst_tx", tx, 1'b1);
    check("rst_busy", tx_busy, 1'b0);
    check("rst_active", active, 1'b0);
    check("rst_ovf", overflow, 1'b0);
    tick(3);

    // single 0x55 frame: latency and exact waveform
    put(8'h55);
    wait_tx_low("t1_start_timeout", k);
    check("t1_latency", k, 3);
    for (int i = 0; i < 40; i++) begin
      if (i > 0) @(negedge clk);
      got_tx[i] = tx;
      got_act[i] = active;
      s = i / CPB;
      exp_tx[i] = (s == 0) ? 1'b0 : (s == 9) ? 1'b1 : k[0] ^ k[0] ^ ((8'h55 >> (s - 1)) & 1);
    end
    @(negedge clk);
    check("t1_wave", got_tx, exp_tx);
    check("t1_active", got_act, {40{1'b1}});
    check("t1_active_end", active, 1'b0);
    @(posedge clk); #1;
    wait_quiet("t1_quiet", 200);
    check("t1_rx", rx_b.size() == 1 ? rx_b[0] : 8'hxx, 8'h55);

    // fill while blocked, overflow on fifth write, then drain in order
    rx_b.delete(); rx_t.delete();
    tx_block = 1'b1;
    tick(3);
    for (int i = 0; i < 5; i++) begin
      tx_data = 8'(i + 1);
      new_tx_data = 1'b1;
      @(posedge clk); #1;
      if (i == 3) check("t2_busy", tx_busy, 1'b1);
      if (i == 4) check("t2_ovf", overflow, 1'b1);
    end
    new_tx_data = 1'b0;
    tick(1);
    check("t2_ovf_pulse", overflow, 1'b0);
    tx_block = 1'b0;
    wait_quiet("t2_quiet", 400);
    check("t2_count", rx_b.size(), 4);
    if (rx_b.size() == 4) begin
      check("t2_order", {rx_b[0], rx_b[1], rx_b[2], rx_b[3]}, 32'h01020304);
      for (int i = 0; i < 3; i++) check("t2_spacing", rx_t[i+1] - rx_t[i], 10*CPB + 1);
    end

    // blocked byte waits, then starts once the flag clears
    rx_b.delete();
    tx_block = 1'b1;
    tick(3);
    put(8'hA5);
    tick(20);
    check("t3_tx_held", tx, 1'b1);
    check("t3_active_held", active, 1'b0);
    tx_block = 1'b0;
    wait_tx_low("t3_start_timeout", k);
    check("t3_latency", k, 5);
    @(posedge clk); #1;
    wait_quiet("t3_quiet", 200);
    check("t3_rx", rx_b.size() == 1 ? rx_b[0] : 8'hxx, 8'hA5);

    // block mid-frame: current frame completes, next byte waits
    rx_b.delete();
    put(8'h3C);
    put(8'h77);
    wait_tx_low("t4_start_timeout", k);
    @(posedge clk); #1;
    tick(3*CPB);
    tx_block = 1'b1;
    w = 0;
    while (cyc < tp + 10*CPB + 2 && w < 100) begin @(posedge clk); #1; w++; end
    tick(30);
    check("t4_first_only", rx_b.size(), 1);
    check("t4_first", rx_b.size() > 0 ? rx_b[0] : 8'hxx, 8'h3C);
    check("t4_held_idle", active, 1'b0);
    tx_block = 1'b0;
    wait_quiet("t4_quiet", 200);
    check("t4_second", rx_b.size() == 2 ? rx_b[1] : 8'hxx, 8'h77);

    // reset mid-frame with three bytes still queued
    rx_b.delete();
    tx_block = 1'b1;
    tick(3);
    put(8'h11); put(8'h22); put(8'h33); put(8'h44);
    tx_block = 1'b0;
    wait_tx_low("t5_start_timeout", k);
    @(posedge clk); #1;
    tick(15);
    #2 rst_n = 1'b0;
    #1;
    check("t5_rst_tx", tx, 1'b1);
    check("t5_rst_busy", tx_busy, 1'b0);
    check("t5_rst_active", active, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    tick(80);
    check("t5_no_frame", rx_b.size(), 0);
    check("t5_idle", tx, 1'b1);

    // random writes and blocking
    for (int i = 0; i < 300; i++) begin
      new_tx_data = ($urandom_range(0, 3) == 0);
      tx_data = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 19) == 0) tx_block = ~tx_block;
      @(posedge clk); #1;
    end
    new_tx_data = 1'b0;
    tx_block = 1'b0;
    wait_quiet("rand_quiet", 2000);
    tick(4);
    check("rand_drained", exp_q.size(), 0);

    // fast instance: random stream respecting tx_busy
    for (int i = 0; i < 12; i++) begin
      w = 0;
      while (tx_busy_f && w < 5000) begin @(posedge clk); #1; w++; end
      check("f_busy_wait", w < 5000, 1'b1);
      tx_data_f = 8'($urandom_range(0, 255));
      new_tx_data_f = 1'b1;
      exp_qf.push_back(tx_data_f);
      @(posedge clk); #1;
      new_tx_data_f = 1'b0;
      tick($urandom_range(0, 400));
    end
    w = 0;
    while (exp_qf.size() > 0 && w < 20000) begin @(posedge clk); #1; w++; end
    check("f_drain", exp_qf.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
